// File: rtl/pcie_egress_sequencer.sv
// ============================================================================
// Module   : pcie_egress_sequencer
// Purpose  : Splits one host MWr32/MRd32 transfer into size- and 4KB-legal TLPs
//            and feeds them to the egress TLP builder one packet at a time.
//            Optional read-tag throttling: PCIE_EGRESS_SEQ_TAG_THROTTLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_egress_sequencer #(
    parameter int MAX_TAGS = 32,
    parameter int TAG_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [31:0] i_address,
    input  logic [23:0] i_dword_count,
    input  logic [13:0] i_flags,
    input  logic [2:0]  i_max_payload,
    input  logic [2:0]  i_max_read_req,
    input  logic        i_cancel,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_egress_enable,
    input  logic        i_egress_finished,
    output logic [7:0]  o_egress_command,
    output logic [13:0] o_egress_flags,
    output logic [31:0] o_egress_address,
    output logic [7:0]  o_egress_tag,
    output logic [10:0] o_pkt_dwords,
    output logic [23:0] o_remaining
`ifdef PCIE_EGRESS_SEQ_TAG_THROTTLE_EN
    ,
    input  logic        i_cpl_done_stb,
    output logic [8:0]  o_outstanding
`endif
);

    localparam logic [7:0] c_cmd_mwr  = 8'h40;
    localparam logic [7:0] c_cmd_mrd  = 8'h00;
    localparam logic [7:0] c_tag_base = 8'(TAG_BASE);
    localparam logic [7:0] c_tag_last = 8'(TAG_BASE + MAX_TAGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_ISSUE   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q;
    logic        write_q;
    logic [2:0]  pay_code_q;
    logic [2:0]  rd_code_q;
    logic        busy_q;
    logic        done_q;
    logic        enable_q;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q;
    logic [7:0]  tag_q;
    logic [10:0] pkt_q;
    logic [23:0] rem_q;

    logic [2:0]  code_sel_d;
    logic [2:0]  code_eff_d;
    logic [10:0] size_limit_d;
    logic [10:0] b4k_d;
    logic [10:0] lim_d;
    logic [10:0] pkt_d;
    logic [31:0] addr_d;
    logic [23:0] rem_d;
    logic [7:0]  tag_d;
    logic        stall_d;

    // Size codes above 5 clamp to the 1024-DWORD maximum.
    always_comb begin
        code_sel_d   = write_q ? pay_code_q : rd_code_q;
        code_eff_d   = (code_sel_d > 3'd5) ? 3'd5 : code_sel_d;
        size_limit_d = 11'd32 << code_eff_d;
        b4k_d        = 11'd1024 - {1'b0, addr_q[11:2]};
        lim_d        = (size_limit_d < b4k_d) ? size_limit_d : b4k_d;
        pkt_d        = (rem_q < {13'd0, lim_d}) ? rem_q[10:0] : lim_d;
        addr_d       = addr_q + {19'd0, pkt_q, 2'b00};
        rem_d        = rem_q - {13'd0, pkt_q};
        tag_d        = (tag_q == c_tag_last) ? c_tag_base : tag_q + 8'd1;
    end

`ifdef PCIE_EGRESS_SEQ_TAG_THROTTLE_EN
    logic [8:0] outstanding_q;
    logic       inc_d;
    logic       dec_d;

    assign inc_d = (state_q == S_ISSUE) && i_egress_finished && !write_q;
    assign dec_d = i_cpl_done_stb && (outstanding_q != 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= 9'd0;
        end else if (inc_d && !i_cpl_done_stb) begin
            outstanding_q <= outstanding_q + 9'd1;
        end else if (dec_d && !inc_d) begin
            outstanding_q <= outstanding_q - 9'd1;
        end
    end

    assign o_outstanding = outstanding_q;
    assign stall_d       = !write_q && (outstanding_q == 9'(MAX_TAGS));
`else
    assign stall_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            pay_code_q <= 3'd0;
            rd_code_q  <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            enable_q   <= 1'b0;
            cmd_q      <= 8'd0;
            addr_q     <= 32'd0;
            tag_q      <= c_tag_base;
            pkt_q      <= 11'd0;
            rem_q      <= 24'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (i_start) begin
                        busy_q     <= 1'b1;
                        write_q    <= i_write;
                        cmd_q      <= i_write ? c_cmd_mwr : c_cmd_mrd;
                        addr_q     <= i_address & 32'hFFFF_FFFC;
                        rem_q      <= i_dword_count;
                        pay_code_q <= i_max_payload;
                        rd_code_q  <= i_max_read_req;
                        state_q    <= (i_dword_count == 24'd0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    pkt_q <= pkt_d;
                    if (i_cancel) begin
                        state_q <= S_DONE;
                    end else if (!stall_d) begin
                        enable_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_egress_finished) begin
                        enable_q <= 1'b0;
                        state_q  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Advance only once the egress has dropped finished, so the
                    // next packet never sees a stale handshake.
                    if (!i_egress_finished) begin
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        if (!write_q) begin
                            tag_q <= tag_d;
                        end
                        state_q <= ((rem_d == 24'd0) || i_cancel) ? S_DONE : S_CALC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_egress_enable  = enable_q;
    assign o_egress_command = cmd_q;
    assign o_egress_flags   = i_flags;
    assign o_egress_address = addr_q;
    assign o_egress_tag     = tag_q;
    assign o_pkt_dwords     = pkt_q;
    assign o_remaining      = rem_q;

endmodule

`default_nettype wire
